// File: rtl/spi_acq_sequencer.sv
// spi_acq_sequencer
//   Owns the shared SPI bus between the pre-amp gain driver and the ADC
//   capture driver. On start it programs the amp once, then fires one ADC
//   conversion per sample period, slotting amp re-programming in between
//   samples when requested. The other bus devices are held deselected.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start / stop / gain_update control requests from top level
//   GO_AMP, DONE_AMP           amp driver handshake (DONE is a level)
//   SPI_CLK_AMP, SPI_MOSI_AMP  amp driver bus signals
//   GO_ADC, DONE_ADC           ADC driver handshake
//   SPI_CLK_ADC                ADC driver bus clock
//   SPI_SCK, SPI_MOSI          muxed shared bus
//   DAC_CS, SF_CE0, FPGA_INIT_B  other bus devices, held inactive (1)
//   running, sample_tick       status
//   error, overrun             sticky flags, cleared by start
//   sample_count               completed ADC transactions
//
// Build option: define SAMPLE_COUNT_EN to add the sample_count port and
// its counter.
module spi_acq_sequencer #(
  parameter int SAMPLE_DIV = 5000,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        gain_update,
  output logic        GO_AMP,
  input  logic        DONE_AMP,
  input  logic        SPI_CLK_AMP,
  input  logic        SPI_MOSI_AMP,
  output logic        GO_ADC,
  input  logic        DONE_ADC,
  input  logic        SPI_CLK_ADC,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        SF_CE0,
  output logic        FPGA_INIT_B,
  output logic        running,
  output logic        sample_tick,
  output logic        error,
  output logic        overrun
`ifdef SAMPLE_COUNT_EN
  ,
  output logic [15:0] sample_count
`endif
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, AMP_GO, AMP_WAIT, ARM, ADC_GO, ADC_WAIT, ERR
  } state_t;

  state_t        state, nxt;
  logic [15:0]   wd_cnt;
  logic [DW-1:0] div_cnt;
  logic          done_amp_q, done_adc_q;
  logic          stop_pend, gain_pend;
  logic          amp_rise, adc_rise, start_acc;

  assign DAC_CS      = 1'b1;
  assign SF_CE0      = 1'b1;
  assign FPGA_INIT_B = 1'b1;

  // DONE is a level that may still be high from the previous run, so only
  // a rising edge counts as completion.
  assign amp_rise  = DONE_AMP & ~done_amp_q;
  assign adc_rise  = DONE_ADC & ~done_adc_q;
  assign running   = (state != IDLE) && (state != ERR);
  assign start_acc = start && ((state == IDLE) || (state == ERR));
  assign sample_tick = running && (div_cnt == DW'(SAMPLE_DIV - 1));

  always_comb begin
    nxt      = state;
    GO_AMP   = 1'b0;
    GO_ADC   = 1'b0;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    case (state)
      IDLE:     if (start) nxt = AMP_GO;
      AMP_GO: begin
        GO_AMP   = 1'b1;
        SPI_SCK  = SPI_CLK_AMP;
        SPI_MOSI = SPI_MOSI_AMP;
        nxt      = AMP_WAIT;
      end
      AMP_WAIT: begin
        SPI_SCK  = SPI_CLK_AMP;
        SPI_MOSI = SPI_MOSI_AMP;
        if (amp_rise)                    nxt = ARM;
        else if (wd_cnt == 16'(TIMEOUT)) nxt = ERR;
      end
      ARM: begin
        if (stop_pend)        nxt = IDLE;
        else if (gain_pend)   nxt = AMP_GO;
        else if (sample_tick) nxt = ADC_GO;
      end
      ADC_GO: begin
        GO_ADC  = 1'b1;
        SPI_SCK = SPI_CLK_ADC;
        nxt     = ADC_WAIT;
      end
      ADC_WAIT: begin
        SPI_SCK = SPI_CLK_ADC;
        if (adc_rise)                    nxt = ARM;
        else if (wd_cnt == 16'(TIMEOUT)) nxt = ERR;
      end
      ERR:      if (start) nxt = AMP_GO;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done_amp_q <= 1'b0;
      done_adc_q <= 1'b0;
      wd_cnt     <= '0;
      div_cnt    <= '0;
      stop_pend  <= 1'b0;
      gain_pend  <= 1'b0;
      error      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= nxt;
      done_amp_q <= DONE_AMP;
      done_adc_q <= DONE_ADC;

      // GO states are the only way into a WAIT state, so clearing there
      // restarts the watchdog for every transaction.
      if ((state == AMP_GO) || (state == ADC_GO))          wd_cnt <= '0;
      else if ((state == AMP_WAIT) || (state == ADC_WAIT)) wd_cnt <= wd_cnt + 16'd1;

      if (start_acc)        div_cnt <= '0;
      else if (sample_tick) div_cnt <= '0;
      else if (running)     div_cnt <= div_cnt + DW'(1);

      if (start_acc)     error <= 1'b0;
      else if (nxt == ERR) error <= 1'b1;

      // A tick is only consumable in ARM; anywhere else it is lost.
      if (start_acc)                         overrun <= 1'b0;
      else if (sample_tick && state != ARM) overrun <= 1'b1;

      if (start_acc || nxt == IDLE) stop_pend <= 1'b0;
      else if (running && stop)     stop_pend <= 1'b1;

      // A new request in the same cycle as amp completion survives.
      if (start_acc || nxt == IDLE)          gain_pend <= 1'b0;
      else if (running && gain_update)       gain_pend <= 1'b1;
      else if (state == AMP_WAIT && amp_rise) gain_pend <= 1'b0;
    end
  end

`ifdef SAMPLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc)                 sample_count <= '0;
    else if (state == ADC_WAIT && adc_rise) sample_count <= sample_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spi_acq_sequencer.sv
// tb_spi_acq_sequencer
//   Bench for spi_acq_sequencer with SAMPLE_DIV=10, TIMEOUT=50. Behavioural
//   amp/ADC driver models answer GO pulses; a queue holds the cycle at which
//   each GO pulse is due and a monitor pops it when a pulse appears. A small
//   table of bus-mux vectors is applied while the DUT sits in a known state.
module tb_spi_acq_sequencer;

  localparam int SDIV = 10;
  localparam int TOUT = 50;

  logic clk = 1'b0;
  logic reset, start, stop, gain_update;
  logic DONE_AMP, SPI_CLK_AMP, SPI_MOSI_AMP, DONE_ADC, SPI_CLK_ADC;
  logic GO_AMP, GO_ADC, SPI_SCK, SPI_MOSI, DAC_CS, SF_CE0, FPGA_INIT_B;
  logic running, sample_tick, error, overrun;
`ifdef SAMPLE_COUNT_EN
  logic [15:0] sample_count;
`endif

  spi_acq_sequencer #(.SAMPLE_DIV(SDIV), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .gain_update(gain_update),
    .GO_AMP(GO_AMP), .DONE_AMP(DONE_AMP),
    .SPI_CLK_AMP(SPI_CLK_AMP), .SPI_MOSI_AMP(SPI_MOSI_AMP),
    .GO_ADC(GO_ADC), .DONE_ADC(DONE_ADC), .SPI_CLK_ADC(SPI_CLK_ADC),
    .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .DAC_CS(DAC_CS), .SF_CE0(SF_CE0), .FPGA_INIT_B(FPGA_INIT_B),
    .running(running), .sample_tick(sample_tick),
    .error(error), .overrun(overrun)
`ifdef SAMPLE_COUNT_EN
    , .sample_count(sample_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver models ----------------
  int amp_lat = 3, amp_c = 0;
  int adc_lat = 5, adc_hold = 0, adc_hold_c = 0, adc_c = 0;
  bit adc_en = 1'b1;

  initial begin
    DONE_AMP = 1'b0;
    forever begin
      @(negedge clk);
      if (amp_c > 0) begin
        amp_c--;
        if (amp_c == 0) DONE_AMP = 1'b1;
      end
      if (GO_AMP) begin
        DONE_AMP = 1'b0;
        amp_c = amp_lat;
      end
    end
  end

  initial begin
    DONE_ADC = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_hold_c > 0) begin
        adc_hold_c--;
        if (adc_hold_c == 0) DONE_ADC = 1'b0;
      end
      if (adc_c > 0) begin
        adc_c--;
        if (adc_c == 0 && adc_en) DONE_ADC = 1'b1;
      end
      if (GO_ADC) begin
        if (adc_hold == 0) DONE_ADC = 1'b0;
        else adc_hold_c = adc_hold;
        adc_c = adc_lat;
      end
    end
  end

  // ---------------- GO scoreboard ----------------
  typedef struct { bit is_adc; int cyc; } go_t;
  go_t sbq[$];

  initial begin
    go_t e;
    forever begin
      @(negedge clk);
      if (GO_AMP || GO_ADC) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL go_unexpected: GO_AMP=%0b GO_ADC=%0b, expected none (cycle %0d)",
                   GO_AMP, GO_ADC, cyc);
        end else begin
          e = sbq.pop_front();
          chk("go_kind_adc", {15'd0, GO_ADC}, {15'd0, e.is_adc});
          chk("go_cycle", 16'(cyc), 16'(e.cyc));
        end
      end
    end
  end

  // ---------------- bus mux vector table ----------------
  localparam int PH_AMP = 0, PH_ADC = 1, PH_NONE = 2;
  typedef struct { int ph; logic ca, ma, cd, e_sck, e_mosi; } vec_t;
  vec_t tbl[8];

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic apply_ph(input int ph);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ph == ph) begin
        SPI_CLK_AMP = tbl[i].ca; SPI_MOSI_AMP = tbl[i].ma; SPI_CLK_ADC = tbl[i].cd;
        #1;
        chk("mux_sck", {15'd0, SPI_SCK}, {15'd0, tbl[i].e_sck});
        chk("mux_mosi", {15'd0, SPI_MOSI}, {15'd0, tbl[i].e_mosi});
        @(negedge clk);
      end
    end
    SPI_CLK_AMP = 1'b0; SPI_MOSI_AMP = 1'b0; SPI_CLK_ADC = 1'b0;
  endtask

  task automatic do_start(output int s);
    s = cyc;
    start = 1'b1;
    sbq.push_back('{is_adc: 1'b0, cyc: s + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic pulse_gain;
    gain_update = 1'b1; @(negedge clk); gain_update = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_go_amp"}, {15'd0, GO_AMP}, 16'd0);
    chk({tag, "_go_adc"}, {15'd0, GO_ADC}, 16'd0);
    chk({tag, "_sck"}, {15'd0, SPI_SCK}, 16'd0);
    chk({tag, "_mosi"}, {15'd0, SPI_MOSI}, 16'd0);
    chk({tag, "_running"}, {15'd0, running}, 16'd0);
    chk({tag, "_tick"}, {15'd0, sample_tick}, 16'd0);
    chk({tag, "_error"}, {15'd0, error}, 16'd0);
    chk({tag, "_overrun"}, {15'd0, overrun}, 16'd0);
    chk({tag, "_selects"}, {13'd0, DAC_CS, SF_CE0, FPGA_INIT_B}, 16'd7);
`ifdef SAMPLE_COUNT_EN
    chk({tag, "_count"}, sample_count, 16'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    tbl[0] = '{PH_AMP,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{PH_AMP,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{PH_AMP,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{PH_ADC,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{PH_ADC,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{PH_ADC,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{PH_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{PH_NONE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset with bus inputs active: everything must stay at reset values.
    reset = 1'b1; start = 1'b0; stop = 1'b0; gain_update = 1'b0;
    SPI_CLK_AMP = 1'b1; SPI_MOSI_AMP = 1'b1; SPI_CLK_ADC = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b0;
    SPI_CLK_AMP = 1'b0; SPI_MOSI_AMP = 1'b0; SPI_CLK_ADC = 1'b0;
    @(negedge clk);

    // 1: slow amp config (20 cycles), mux follows amp, stop from ARM.
    amp_lat = 20;
    do_start(s);
    chk("t1_running", {15'd0, running}, 16'd1);
    wait_to(s + 3);  apply_ph(PH_AMP);
    wait_to(s + 23); pulse_stop;
    wait_to(s + 24);
    chk("t1_running_arm", {15'd0, running}, 16'd1);
    chk("t1_overrun", {15'd0, overrun}, 16'd1);
    wait_to(s + 25);
    chk("t1_idle", {15'd0, running}, 16'd0);
    wait_to(s + 26); apply_ph(PH_NONE);

    // 2: steady sampling, GO_ADC every SDIV cycles, no overrun.
    amp_lat = 3;
    do_start(s);
    for (int m = 1; m <= 3; m++) sbq.push_back('{is_adc: 1'b1, cyc: s + SDIV*m + 1});
    chk("t2_overrun_clr", {15'd0, overrun}, 16'd0);
    wait_to(s + 6);  apply_ph(PH_NONE);
    wait_to(s + 12); apply_ph(PH_ADC);
`ifdef SAMPLE_COUNT_EN
    wait_to(s + 17); chk("t2_count1", sample_count, 16'd1);
    wait_to(s + 27); chk("t2_count2", sample_count, 16'd2);
`endif
    wait_to(s + 33); pulse_stop;
    wait_to(s + 37);
    chk("t2_running", {15'd0, running}, 16'd1);
    wait_to(s + 38);
    chk("t2_idle", {15'd0, running}, 16'd0);
    chk("t2_overrun", {15'd0, overrun}, 16'd0);
`ifdef SAMPLE_COUNT_EN
    chk("t2_count3", sample_count, 16'd3);
`endif

    // 3: gain request mid ADC_WAIT -> GO_AMP before next GO_ADC; tick lost.
    amp_lat = 3;
    do_start(s);
    sbq.push_back('{is_adc: 1'b1, cyc: s + 11});
    sbq.push_back('{is_adc: 1'b0, cyc: s + 18});
    sbq.push_back('{is_adc: 1'b1, cyc: s + 41});
    wait_to(s + 13); pulse_gain;
    amp_lat = 20;
    wait_to(s + 17); chk("t3_overrun_pre", {15'd0, overrun}, 16'd0);
    wait_to(s + 20); chk("t3_overrun_edge", {15'd0, overrun}, 16'd0);
    wait_to(s + 21); chk("t3_overrun_set", {15'd0, overrun}, 16'd1);
    wait_to(s + 42); pulse_stop;
    wait_to(s + 48); chk("t3_idle", {15'd0, running}, 16'd0);

    // 4: ADC never completes -> ERR after TOUT cycles of ADC_WAIT; restart.
    amp_lat = 3; adc_en = 1'b0;
    do_start(s);
    sbq.push_back('{is_adc: 1'b1, cyc: s + 11});
    wait_to(s + 62);
    SPI_CLK_ADC = 1'b1; #1;
    chk("t4_error_pre", {15'd0, error}, 16'd0);
    chk("t4_sck_adc", {15'd0, SPI_SCK}, 16'd1);
    wait_to(s + 63);
    chk("t4_error", {15'd0, error}, 16'd1);
    chk("t4_running", {15'd0, running}, 16'd0);
    chk("t4_sck_err", {15'd0, SPI_SCK}, 16'd0);
    SPI_CLK_ADC = 1'b0; adc_en = 1'b1;
    wait_to(s + 70);
    do_start(s);
    chk("t4_error_clr", {15'd0, error}, 16'd0);
    chk("t4_running2", {15'd0, running}, 16'd1);
    pulse_stop;
    wait_to(s + 6); chk("t4_idle", {15'd0, running}, 16'd0);

    // 5: stop while DONE_ADC still high from last run; exit only on true rise.
    adc_hold = 0; adc_lat = 5;
    do_start(s);
    sbq.push_back('{is_adc: 1'b1, cyc: s + 11});
    sbq.push_back('{is_adc: 1'b1, cyc: s + 21});
    wait_to(s + 18); adc_hold = 4; adc_lat = 8;
    wait_to(s + 23); pulse_stop;
    wait_to(s + 28); chk("t5_no_early", {15'd0, running}, 16'd1);
    wait_to(s + 30); chk("t5_arm", {15'd0, running}, 16'd1);
    wait_to(s + 31); chk("t5_idle", {15'd0, running}, 16'd0);
`ifdef SAMPLE_COUNT_EN
    chk("t5_count", sample_count, 16'd2);
`endif
    adc_hold = 0; adc_lat = 5;

    // 6: reset in the middle of AMP_WAIT aborts at once.
    amp_lat = 20;
    do_start(s);
    wait_to(s + 5);
    reset = 1'b1; SPI_CLK_AMP = 1'b1; SPI_MOSI_AMP = 1'b1; SPI_CLK_ADC = 1'b1; #1;
    chk("t6_sck_amp", {15'd0, SPI_SCK}, 16'd1);
    wait_to(s + 6);
    chk_reset_outs("t6");
    reset = 1'b0;
    wait_to(s + 8);
    chk("t6_stay_idle", {15'd0, running}, 16'd0);
    SPI_CLK_AMP = 1'b0; SPI_MOSI_AMP = 1'b0; SPI_CLK_ADC = 1'b0;

    wait_to(s + 30);
    chk("sb_empty", 16'(sbq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_acq_sequencer.md
Name: spi_acq_sequencer

Overview:
Sequences the shared SPI bus between the pre-amp gain driver and the ADC capture driver. On start it configures the amp once, then triggers ADC conversions at a fixed sample rate. It services gain re-programming requests between samples. It muxes each driver's SCK/MOSI onto the single bus and holds the other SPI devices deselected. It sits between top-level control and the amp/ADC driver blocks.

Parameters:
SAMPLE_DIV, 5000, clk cycles between sample ticks (≥2; 10 kHz at 50 MHz)
TIMEOUT, 4095, max clk cycles to wait for a driver DONE before error (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin acquisition; also clears error/overrun
stop  in  1  request return to idle after current transaction
gain_update  in  1  request amp re-programming before next sample
GO_AMP  out  1  one-cycle start pulse to amp driver
DONE_AMP  in  1  amp driver done (level, drops when GO seen)
SPI_CLK_AMP  in  1  amp driver SCK
SPI_MOSI_AMP  in  1  amp driver MOSI
GO_ADC  out  1  one-cycle start pulse to ADC driver
DONE_ADC  in  1  ADC driver done (same level semantics)
SPI_CLK_ADC  in  1  ADC driver SCK
SPI_SCK  out  1  muxed bus clock
SPI_MOSI  out  1  muxed bus data
DAC_CS  out  1  constant 1
SF_CE0  out  1  constant 1
FPGA_INIT_B  out  1  constant 1
running  out  1  high from start acceptance until IDLE
sample_tick  out  1  one-cycle pulse per sample-period terminal count
error  out  1  sticky DONE timeout flag
overrun  out  1  sticky flag: tick arrived while not in ARM
sample_count  out  16  completed ADC transactions (SAMPLE_COUNT_EN only)

Behaviour:
- Reset values: GO_AMP=0, GO_ADC=0, SPI_SCK=0, SPI_MOSI=0, running=0, sample_tick=0, error=0, overrun=0, sample_count=0. State=IDLE. Pending flags cleared. Reset mid-transaction aborts immediately. DAC_CS/SF_CE0/FPGA_INIT_B are 1 always.
- DONE completion = rising edge of DONE_x against its registered previous value (level may still be high from the last run).
- States: IDLE, AMP_GO, AMP_WAIT, ARM, ADC_GO, ADC_WAIT, ERR.
- IDLE: start=1 → AMP_GO. Clears error/overrun, gain/stop pending, and the sample divider. running goes 1 the next cycle.
- AMP_GO: GO_AMP=1 for exactly this one cycle → AMP_WAIT. Latency is start sampled at cycle N → GO_AMP high in N+1.
- AMP_WAIT: DONE_AMP rise → ARM and clear gain pending. Watchdog reaching TIMEOUT → ERR.
- ARM: evaluate in priority order:
  1. stop pending → IDLE.
  2. gain pending → AMP_GO.
  3. sample_tick → ADC_GO.
  4. otherwise stay in ARM.
- ADC_GO: GO_ADC=1 for one cycle → ADC_WAIT.
- ADC_WAIT: DONE_ADC rise → ARM and increment sample_count. Watchdog reaching TIMEOUT → ERR.
- ERR: error=1, running=0, both GO outputs 0, bus owner none. Only start (→AMP_GO) or reset leaves ERR.
- Watchdog: 16-bit counter, cleared on entry to each WAIT state. It increments every WAIT cycle; ERR is entered on the cycle the count equals TIMEOUT.
- Sample divider: counts 0..SAMPLE_DIV-1 while running and wraps. sample_tick=1 on the cycle the count equals SAMPLE_DIV-1.
- A tick arriving in any state other than ARM (including AMP re-config) is dropped and sets overrun.
- stop and gain_update are latched as pending on any cycle while running. A stop is honoured only in ARM, so in-flight transactions always complete. If stop and gain are both pending, stop wins and gain pending is cleared.
- start while running is ignored. stop in IDLE is ignored.
- Bus owner follows state:
  - AMP in AMP_GO/AMP_WAIT: SPI_SCK=SPI_CLK_AMP, SPI_MOSI=SPI_MOSI_AMP.
  - ADC in ADC_GO/ADC_WAIT: SPI_SCK=SPI_CLK_ADC, SPI_MOSI=0.
  - None otherwise: both 0.
  - The mux is combinational from the registered state (no extra latency).
- sample_count wraps 0xFFFF→0x0000.

Optional Feature:
SAMPLE_COUNT_EN:
- Defined: sample_count port and its 16-bit counter exist. The counter is cleared by reset and on start acceptance.
- Undefined: the port and counter are absent, and all other behaviour is unchanged.

Test Plan:
- Start, amp model asserts DONE_AMP 20 cycles after GO → exactly one GO_AMP pulse, one cycle after start; ARM reached; SPI_SCK follows SPI_CLK_AMP only during AMP states.
- SAMPLE_DIV=10, ADC model done in 5 cycles → GO_ADC every 10 cycles; sample_count increments by 1 per transaction; overrun stays 0.
- gain_update pulsed mid ADC_WAIT → after DONE_ADC, next action is GO_AMP, not GO_ADC; the tick during AMP_WAIT sets overrun=1.
- DONE_ADC never asserted, TIMEOUT=50 → ERR 50 cycles into ADC_WAIT; error=1, running=0, SPI_SCK=0; a later start clears error and issues GO_AMP.
- stop pulsed during ADC_WAIT with DONE_ADC held high from the previous run → no early exit; after a true DONE_ADC rise, IDLE and running=0.
- reset asserted mid AMP_WAIT → next cycle all outputs at reset values and the DAC/flash selects still 1; SAMPLE_COUNT_EN build shows sample_count=0.
